hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline hazard controller that drives the hold and bubble controls of the IF/ID and ID/EX pipeline registers. It detects load-use hazards from the ID/EX outputs against the source registers of the instruction held in IF/ID. It also sequences squashing of wrong-path instructions after a taken branch resolves in MEM. It sits beside the pipeline registers and feeds their write-enable, flush and bubble inputs.

## Interface
- FLUSH_CYCLES, 1: extra cycles ifid_flush stays high after the taken-branch cycle (range 0-7)
- CNT_W, 32: width of performance counters
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- id_rs1  in  5  rs1 field of instruction in IF/ID
- id_rs2  in  5  rs2 field of instruction in IF/ID
- id_uses_rs2  in  1  IF/ID instruction reads rs2 (R/S/B-type)
- ex_mem_read  in  1  MemRead output of ID/EX
- ex_rd  in  5  rd output of ID/EX
- mem_branch_taken  in  1  branch in MEM resolved taken
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  force all ID/EX control inputs to 0
- exmem_flush  out  1  clear EX/MEM control bits
- state  out  2  FSM state: RUN=0, LU_STALL=1, FLUSH=2
- stall_cnt  out  CNT_W  load-use stall count
- flush_cnt  out  CNT_W  taken-branch flush count

## Operation
- load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, exmem_flush=0.
- RUN, mem_branch_taken=1: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1.
  - FLUSH_CYCLES>0: load squash counter with FLUSH_CYCLES and go to FLUSH.
  - FLUSH_CYCLES=0: stay in RUN.
- RUN, load_use=1 and no taken branch: pc_write=0, ifid_write=0, idex_bubble=1. Go to LU_STALL.
- LU_STALL: load_use detection is masked and default outputs apply. A taken branch is handled exactly as in RUN. Otherwise return to RUN after one cycle.
- FLUSH: ifid_flush=1 and the counter decrements each cycle. Go to RUN in the cycle the counter reaches 1.
  - A taken branch during FLUSH reloads the counter and repeats the RUN taken-branch outputs.
  - load_use is ignored during FLUSH.
- Priority: mem_branch_taken over load_use, always.
- Reset low: outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=0. On the next edge: state=RUN, squash counter=0, perf counters=0.

## Timing
- Outputs are combinational (Mealy) from the registered state and current inputs, with zero-cycle latency so the stall lands on the hazard cycle.
- A load-use stall lasts exactly one cycle. A taken branch squashes for 1+FLUSH_CYCLES cycles.
- State and counters update on posedge clk only.
- Reset asserted mid-FLUSH or mid-LU_STALL aborts the sequence; the first cycle after release is RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle load_use causes pc_write=0.
  - flush_cnt increments on each taken-branch event cycle.
  - Both counters saturate at all-ones and clear on reset.
- HAZARD_PERF_CNT_EN undefined: the ports remain, are tied to 0, and no counter flops are built.

## Structure
- The package hazard_pkg holds:
  - the state enum typedef (RUN, LU_STALL, FLUSH);
  - REG_X0 = 5'd0;
  - the 3-bit squash counter width constant.
- One sub-module, hazard_sat_counter (CNT_W, inc, clear, count), is instantiated twice under HAZARD_PERF_CNT_EN.

## Test plan
- Reset: hold reset low 2 cycles -> pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. After release -> state=0, pc_write=1.
- Load-use hit: ex_mem_read=1, ex_rd=5, id_rs1=5 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle state=1 with defaults, then state=0.
- Non-hazards:
  - ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall.
  - ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
  - ex_mem_read=0 with matching rd -> no stall.
- Branch vs load-use with FLUSH_CYCLES=2: assert mem_branch_taken and load_use together -> ifid_flush=idex_bubble=exmem_flush=1, pc_write=1. Then ifid_flush=1 for 2 cycles in state=2, then RUN.
- Reset mid-FLUSH: pull reset low in the second FLUSH cycle -> next edge state=0. After release ifid_flush=0.
- Counters (HAZARD_PERF_CNT_EN, CNT_W=2): 3 load-use stalls and 2 branches -> stall_cnt=3, flush_cnt=2. A 4th stall -> stall_cnt stays 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int SQ_CNT_W = 3;
  typedef logic [SQ_CNT_W-1:0] sq_cnt_t;

endpackage

`default_nettype wire

// File: rtl/hazard_sat_counter.sv
// ============================================================================
// hazard_sat_counter : saturating event counter with synchronous clear
// Revision           : 1.0
// ============================================================================
`default_nettype none

module hazard_sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl : load-use stall and taken-branch squash control for the
//                     IF/ID and ID/EX registers. Optional HAZARD_PERF_CNT_EN.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam sq_cnt_t FLUSH_LOAD = sq_cnt_t'(FLUSH_CYCLES);

  state_e  state_q, state_d;
  sq_cnt_t sq_cnt_q, sq_cnt_d;
  logic    load_use;

  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    sq_cnt_q <= sq_cnt_d;
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (!reset) begin
      state_d  = RUN;
      sq_cnt_d = '0;
    end else if (mem_branch_taken) begin
      // A taken branch preempts every state, including an in-progress squash.
      if (FLUSH_CYCLES > 0) begin
        state_d  = FLUSH;
        sq_cnt_d = FLUSH_LOAD;
      end else begin
        state_d  = RUN;
        sq_cnt_d = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            state_d = LU_STALL;
          end
        end
        LU_STALL: begin
          state_d = RUN;
        end
        FLUSH: begin
          if (sq_cnt_q <= sq_cnt_t'(1)) begin
            state_d  = RUN;
            sq_cnt_d = '0;
          end else begin
            sq_cnt_d = sq_cnt_q - sq_cnt_t'(1);
          end
        end
        default: begin
          state_d  = RUN;
          sq_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = reset && (state_q == RUN) && load_use && !mem_branch_taken;
  assign flush_inc = reset && mem_branch_taken;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall_inc),
    .clear (!reset),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (flush_inc),
    .clear (!reset),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
